// File: rtl/mem_req_scheduler.sv
// rtl/mem_req_scheduler.sv - round-robin icache/dcache arbiter onto the ExtMemModel request channel
// Optional build macro: MEM_SCHED_PERF_EN adds ic_grant_cnt, dc_grant_cnt, ic_stall_cnt outputs.
module mem_req_scheduler #(
    parameter int ADDR_BITS       = 28,
    parameter int TAG_BITS        = 5,
    parameter int DATA_BEATS      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ic_req_valid,
    output logic                 ic_req_ready,
    input  logic [ADDR_BITS-1:0] ic_req_addr,
    output logic                 ic_resp_valid,
    input  logic                 dc_req_valid,
    output logic                 dc_req_ready,
    input  logic                 dc_req_rw,
    input  logic [ADDR_BITS-1:0] dc_req_addr,
    output logic                 dc_resp_valid,
    input  logic                 dc_wdata_valid,
    output logic                 dc_wdata_ready,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_rw,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [TAG_BITS-1:0]  mem_req_tag,
    output logic                 mem_req_data_valid,
    input  logic                 mem_req_data_ready,
    input  logic                 mem_resp_valid,
    input  logic [TAG_BITS-1:0]  mem_resp_tag,
    output logic                 busy
`ifdef MEM_SCHED_PERF_EN
    ,
    output logic [31:0]          ic_grant_cnt,
    output logic [31:0]          dc_grant_cnt,
    output logic [31:0]          ic_stall_cnt
`endif
);

    localparam int ID_BITS = TAG_BITS - 1;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int BEAT_W  = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WDATA} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_owner;        // 0 = icache, 1 = dcache
    logic               r_rw;
    logic               r_rr_dc;        // last granted requester was the dcache
    logic [CNT_W-1:0]   r_outstanding;
    logic [ID_BITS-1:0] r_id;
    logic [BEAT_W-1:0]  r_beat;

    logic w_rd_ok;
    logic w_ic_elig;
    logic w_dc_elig;
    logic w_grant;
    logic w_grant_dc;
    logic w_accept;
    logic w_rd_accept;
    logic w_beat_fire;

    // Reads are throttled by the in-flight limit; dcache writes never are.
    assign w_rd_ok     = (r_outstanding < MAX_CNT);
    assign w_ic_elig   = ic_req_valid && w_rd_ok;
    assign w_dc_elig   = dc_req_valid && (dc_req_rw || w_rd_ok);
    assign w_accept    = (r_state == ISSUE) && mem_req_ready;
    assign w_rd_accept = w_accept && !r_rw;
    assign w_beat_fire = (r_state == WDATA) && dc_wdata_valid && mem_req_data_ready;

    assign ic_resp_valid = mem_resp_valid && !mem_resp_tag[0];
    assign dc_resp_valid = mem_resp_valid && mem_resp_tag[0];
    assign busy          = (r_state != IDLE) || (r_outstanding != '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode, arbitration and channel muxing.
    always_comb begin
        w_next             = r_state;
        w_grant            = 1'b0;
        w_grant_dc         = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        ic_req_ready       = 1'b0;
        dc_req_ready       = 1'b0;
        mem_req_data_valid = 1'b0;
        dc_wdata_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ic_elig || w_dc_elig) begin
                    w_grant    = 1'b1;
                    w_grant_dc = w_dc_elig && (!w_ic_elig || !r_rr_dc);
                    w_next     = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = r_rw;
                mem_req_addr  = r_owner ? dc_req_addr : ic_req_addr;
                mem_req_tag   = r_rw ? TAG_BITS'(1) : {r_id, r_owner};
                ic_req_ready  = mem_req_ready && !r_owner;
                dc_req_ready  = mem_req_ready && r_owner;
                if (mem_req_ready) w_next = r_rw ? WDATA : IDLE;
            end
            WDATA: begin
                mem_req_data_valid = dc_wdata_valid;
                dc_wdata_ready     = mem_req_data_ready;
                if (w_beat_fire && (r_beat == LAST_BEAT)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the winner at grant; move the round-robin pointer on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= 1'b0;
            r_rw    <= 1'b0;
            r_rr_dc <= 1'b1;
        end else begin
            if (w_grant) begin
                r_owner <= w_grant_dc;
                r_rw    <= w_grant_dc && dc_req_rw;
            end
            if (w_accept) r_rr_dc <= r_owner;
        end
    end

    // Reads in flight: accepted read adds one, response beat removes one, saturating at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else if (w_rd_accept && !mem_resp_valid) begin
            r_outstanding <= r_outstanding + CNT_W'(1);
        end else if (!w_rd_accept && mem_resp_valid && (r_outstanding != '0)) begin
            r_outstanding <= r_outstanding - CNT_W'(1);
        end
    end

    // Read id advances per accepted read and wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_id <= '0;
        else if (w_rd_accept) r_id <= r_id + ID_BITS'(1);
    end

    // Write-beat counter restarts when a write is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   r_beat <= '0;
        else if (w_accept && r_rw)   r_beat <= '0;
        else if (w_beat_fire)        r_beat <= r_beat + BEAT_W'(1);
    end

`ifdef MEM_SCHED_PERF_EN
    // Free-running grant and icache stall counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ic_grant_cnt <= '0;
            dc_grant_cnt <= '0;
            ic_stall_cnt <= '0;
        end else begin
            if (ic_req_ready)                  ic_grant_cnt <= ic_grant_cnt + 32'd1;
            if (dc_req_ready)                  dc_grant_cnt <= dc_grant_cnt + 32'd1;
            if (ic_req_valid && !ic_req_ready) ic_stall_cnt <= ic_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_scheduler.sv
// tb/tb_mem_req_scheduler.sv - vector table, corner sequences and random run against a reference model
module tb_mem_req_scheduler;

    localparam int AB = 28;
    localparam int TB = 5;
    localparam int DB = 4;
    localparam int MO = 4;

    logic          clk;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [AB-1:0] ic_req_addr;
    logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_resp_valid;
    logic [AB-1:0] dc_req_addr;
    logic          dc_wdata_valid, dc_wdata_ready;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AB-1:0] mem_req_addr;
    logic [TB-1:0] mem_req_tag;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic          mem_resp_valid;
    logic [TB-1:0] mem_resp_tag;
    logic          busy;
    logic [8:0]    w_flags;

    mem_req_scheduler #(.ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BEATS(DB), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_resp_valid(dc_resp_valid),
        .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .busy(busy)
    );

    assign w_flags = {ic_req_ready, dc_req_ready, mem_req_valid, mem_req_rw, mem_req_data_valid,
                      dc_wdata_ready, ic_resp_valid, dc_resp_valid, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of the channel.
    int         m_owner;   // -1 none, 0 ic, 1 dc holding the channel
    int         m_left;    // write beats still owed
    int         m_out;
    int         m_id;
    int         m_last;
    bit         m_rw;
    logic [8:0] e_flags;
    logic [4:0] e_tag;
    logic [27:0] e_addr;

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_out = 0; m_id = 0; m_last = 1; m_rw = 0;
    endtask

    task automatic model_eval();
        bit iss;
        bit wd;
        iss = (m_owner >= 0);
        wd  = (m_left > 0);
        e_flags = {iss && m_owner == 0 && mem_req_ready, iss && m_owner == 1 && mem_req_ready,
                   iss, iss && m_rw, wd && dc_wdata_valid, wd && mem_req_data_ready,
                   mem_resp_valid && !mem_resp_tag[0], mem_resp_valid && mem_resp_tag[0],
                   iss || wd || (m_out > 0)};
        e_tag  = !iss ? 5'd0 : (m_rw ? 5'd1 : 5'(m_id * 2 + m_owner));
        e_addr = !iss ? 28'd0 : (m_owner == 1 ? dc_req_addr : ic_req_addr);
    endtask

    task automatic model_step();
        bit rd_acc;
        bit ic_ok;
        bit dc_ok;
        rd_acc = 0;
        if (m_owner < 0 && m_left == 0) begin
            ic_ok = ic_req_valid && (m_out < MO);
            dc_ok = dc_req_valid && (dc_req_rw || (m_out < MO));
            if (ic_ok && dc_ok) m_owner = (m_last == 1) ? 0 : 1;
            else if (ic_ok)     m_owner = 0;
            else if (dc_ok)     m_owner = 1;
            if (m_owner >= 0) m_rw = (m_owner == 1) && dc_req_rw;
        end else if (m_owner >= 0) begin
            if (mem_req_ready) begin
                m_last = m_owner;
                if (m_rw) m_left = DB;
                else begin
                    rd_acc = 1;
                    m_id = (m_id + 1) % (1 << (TB - 1));
                end
                m_owner = -1;
            end
        end else if (dc_wdata_valid && mem_req_data_ready) begin
            m_left--;
        end
        if (rd_acc && mem_resp_valid) m_out = m_out;
        else if (rd_acc)              m_out++;
        else if (mem_resp_valid && m_out > 0) m_out--;
    endtask

    // One clock: model comparison before the edge, model advance at the edge.
    task automatic cycle();
        #1;
        model_eval();
        check("model_flags", 32'(w_flags), 32'(e_flags));
        check("model_tag", 32'(mem_req_tag), 32'(e_tag));
        check("model_addr", 32'(mem_req_addr), 32'(e_addr));
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clr_in();
        ic_req_valid = 0; dc_req_valid = 0; dc_req_rw = 0; dc_wdata_valid = 0;
        mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_tag = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr_in();
        model_reset();
        @(negedge clk);
        #1;
        check("reset_flags", 32'(w_flags), 32'd0);
        check("reset_tag_addr", 32'({mem_req_tag, mem_req_addr}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          icv, dcv, dcrw, mrr, wv, mdr, rv;
        logic [4:0]  rt;
        logic [8:0]  ef;   // {icr,dcr,mv,rw,dv,wr,icresp,dcresp,busy}
        logic [4:0]  et;
        logic [27:0] ea;
    } vec_t;

    vec_t vec_q[$];
    vec_t v;
    bit   ic_pend, dc_pend;

    initial begin
        reset = 1'b1;
        ic_req_addr = 28'h100;
        dc_req_addr = 28'h200;
        clr_in();
        model_reset();

        // Single ic read and its response.
        vec_q.push_back('{1,1,0,0,1,0,0,0,5'd0,9'b000000000,5'd0,28'h0});
        vec_q.push_back('{0,1,0,0,1,0,0,0,5'd0,9'b101000001,5'd0,28'h100});
        vec_q.push_back('{0,0,0,0,1,0,0,0,5'd0,9'b000000001,5'd0,28'h0});
        vec_q.push_back('{0,0,0,0,1,0,0,1,5'd0,9'b000000101,5'd0,28'h0});
        vec_q.push_back('{0,0,0,0,1,0,0,0,5'd0,9'b000000000,5'd0,28'h0});
        // Alternating grants, limit stall, write beats with ready gaps, slot freed by response.
        vec_q.push_back('{1,1,1,0,1,0,0,0,5'd0,9'b000000000,5'd0,28'h0});
        vec_q.push_back('{0,1,1,0,1,0,0,0,5'd0,9'b101000001,5'd0,28'h100});
        vec_q.push_back('{0,1,1,0,1,0,0,0,5'd0,9'b000000001,5'd0,28'h0});
        vec_q.push_back('{0,1,1,0,1,0,0,0,5'd0,9'b011000001,5'b00011,28'h200});
        vec_q.push_back('{0,1,1,0,1,0,0,0,5'd0,9'b000000001,5'd0,28'h0});
        vec_q.push_back('{0,1,1,0,1,0,0,0,5'd0,9'b101000001,5'b00100,28'h100});
        vec_q.push_back('{0,1,1,0,1,0,0,0,5'd0,9'b000000001,5'd0,28'h0});
        vec_q.push_back('{0,1,1,0,1,0,0,0,5'd0,9'b011000001,5'b00111,28'h200});
        vec_q.push_back('{0,1,0,0,1,0,0,0,5'd0,9'b000000001,5'd0,28'h0});
        vec_q.push_back('{0,1,1,1,1,0,0,0,5'd0,9'b000000001,5'd0,28'h0});
        vec_q.push_back('{0,1,1,1,1,0,1,0,5'd0,9'b011100001,5'b00001,28'h200});
        vec_q.push_back('{0,1,0,0,1,1,1,0,5'd0,9'b000011001,5'd0,28'h0});
        vec_q.push_back('{0,1,0,0,1,1,0,0,5'd0,9'b000010001,5'd0,28'h0});
        vec_q.push_back('{0,1,0,0,1,1,1,0,5'd0,9'b000011001,5'd0,28'h0});
        vec_q.push_back('{0,1,0,0,1,1,1,0,5'd0,9'b000011001,5'd0,28'h0});
        vec_q.push_back('{0,1,0,0,1,1,1,0,5'd0,9'b000011001,5'd0,28'h0});
        vec_q.push_back('{0,1,0,0,1,1,1,1,5'd0,9'b000000101,5'd0,28'h0});
        vec_q.push_back('{0,1,0,0,1,0,0,0,5'd0,9'b000000001,5'd0,28'h0});
        vec_q.push_back('{0,1,0,0,1,0,0,0,5'd0,9'b101000001,5'b01000,28'h100});
        // Issue hold, response alongside an accepted read, underflow at zero.
        vec_q.push_back('{1,1,0,0,1,0,0,0,5'd0,9'b000000000,5'd0,28'h0});
        vec_q.push_back('{0,1,0,0,0,0,0,0,5'd0,9'b001000001,5'd0,28'h100});
        vec_q.push_back('{0,1,0,0,1,0,0,0,5'd0,9'b101000001,5'd0,28'h100});
        vec_q.push_back('{0,1,0,0,1,0,0,0,5'd0,9'b000000001,5'd0,28'h0});
        vec_q.push_back('{0,1,0,0,1,0,0,1,5'b00001,9'b101000011,5'b00010,28'h100});
        vec_q.push_back('{0,0,0,0,1,0,0,0,5'd0,9'b000000001,5'd0,28'h0});
        vec_q.push_back('{0,0,0,0,1,0,0,1,5'b00011,9'b000000011,5'd0,28'h0});
        vec_q.push_back('{0,0,0,0,1,0,0,0,5'd0,9'b000000000,5'd0,28'h0});
        vec_q.push_back('{0,0,0,0,1,0,0,1,5'd0,9'b000000100,5'd0,28'h0});
        vec_q.push_back('{0,0,0,0,1,0,0,0,5'd0,9'b000000000,5'd0,28'h0});

        for (int i = 0; i < vec_q.size(); i++) begin
            v = vec_q[i];
            if (v.rst) do_reset();
            ic_req_valid = v.icv; dc_req_valid = v.dcv; dc_req_rw = v.dcrw;
            mem_req_ready = v.mrr; dc_wdata_valid = v.wv; mem_req_data_ready = v.mdr;
            mem_resp_valid = v.rv; mem_resp_tag = v.rt;
            #1;
            check($sformatf("vec%0d_flags", i), 32'(w_flags), 32'(v.ef));
            check($sformatf("vec%0d_tag", i), 32'(mem_req_tag), 32'(v.et));
            check($sformatf("vec%0d_addr", i), 32'(mem_req_addr), 32'(v.ea));
            cycle();
        end

        // Async reset in the middle of a write burst.
        do_reset();
        ic_req_valid = 1; ic_req_addr = 28'h40; mem_req_ready = 1;
        cycle(); cycle();
        ic_req_valid = 0; dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h300;
        cycle(); cycle();
        dc_req_valid = 0; dc_wdata_valid = 1; mem_req_data_ready = 1;
        cycle(); cycle();
        #2;
        reset = 1'b1;
        #1;
        check("rst_wdata_flags", 32'(w_flags), 32'd0);
        check("rst_wdata_tag_addr", 32'({mem_req_tag, mem_req_addr}), 32'd0);
        model_reset();
        @(negedge clk);
        clr_in();
        reset = 1'b0;
        ic_req_valid = 1; ic_req_addr = 28'h140; mem_req_ready = 1;
        cycle();
        #1;
        check("post_rst_flags", 32'(w_flags), 32'(9'b101000001));
        check("post_rst_tag", 32'(mem_req_tag), 32'd0);
        cycle();
        ic_req_valid = 0;

        // Random traffic checked cycle by cycle against the model.
        do_reset();
        ic_pend = 0; dc_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!ic_pend && $urandom_range(3) == 0) begin
                ic_pend = 1; ic_req_addr = 28'($urandom);
            end
            if (!dc_pend && $urandom_range(3) == 0) begin
                dc_pend = 1; dc_req_rw = ($urandom_range(2) == 0); dc_req_addr = 28'($urandom);
            end
            ic_req_valid       = ic_pend;
            dc_req_valid       = dc_pend;
            mem_req_ready      = ($urandom_range(2) != 0);
            mem_req_data_ready = ($urandom_range(1) == 1);
            dc_wdata_valid     = ($urandom_range(3) != 0);
            mem_resp_valid     = ((m_out > 0) && $urandom_range(2) == 0) || ($urandom_range(39) == 0);
            mem_resp_tag       = 5'($urandom);
            cycle();
            if (e_flags[8]) ic_pend = 0;
            if (e_flags[7]) dc_pend = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
